// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin write arbiter for an 8 x 16-bit register file,
// with a per-register pending-write scoreboard used for hazard checks.
module rf_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [2:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [2:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ready,
    input  logic        reserve_en,
    input  logic [2:0]  reserve_reg,
    input  logic [2:0]  chk1_sel,
    input  logic [2:0]  chk2_sel,
    output logic        chk1_busy,
    output logic        chk2_busy,
    input  logic        flush,
    output logic        write,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic        err
);

    logic        r_rr_ptr;
    logic        r_write;
    logic [2:0]  r_writeregsel;
    logic [15:0] r_writedata;
    logic        r_err;

    logic        w_gnt_a;
    logic        w_gnt_b;
    logic        w_xfer;
    logic [2:0]  w_gnt_reg;
    logic [15:0] w_gnt_data;
    logic [7:0]  w_nz;
    logic [7:0]  w_ovf;
    logic [7:0]  w_unf;

    // Grants are gated by rst so readies stay low while reset is held.
    assign w_gnt_a    = rst & ~flush & a_valid & (~b_valid | ~r_rr_ptr);
    assign w_gnt_b    = rst & ~flush & b_valid & (~a_valid |  r_rr_ptr);
    assign w_xfer     = w_gnt_a | w_gnt_b;
    assign w_gnt_reg  = w_gnt_a ? a_reg  : b_reg;
    assign w_gnt_data = w_gnt_a ? a_data : b_data;

    assign a_ready = w_gnt_a;
    assign b_ready = w_gnt_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= 1'b0;
        end else if (flush) begin
            r_rr_ptr <= 1'b0;
        end else if (a_valid && b_valid && w_xfer) begin
            r_rr_ptr <= w_gnt_a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write       <= 1'b0;
            r_writeregsel <= 3'd0;
            r_writedata   <= 16'd0;
        end else if (w_xfer) begin
            r_write       <= 1'b1;
            r_writeregsel <= w_gnt_reg;
            r_writedata   <= w_gnt_data;
        end else begin
            r_write       <= 1'b0;
        end
    end

    // One saturating pending-write counter per register; a reserve and a
    // retiring write hitting the same register in one cycle cancel out.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cnt
            logic [1:0] r_cnt;
            logic       w_inc;
            logic       w_dec;

            assign w_inc     = reserve_en & ~flush & (reserve_reg == 3'(gi));
            assign w_dec     = w_xfer & (w_gnt_reg == 3'(gi));
            assign w_ovf[gi] = w_inc & ~w_dec & (r_cnt == 2'd3);
            assign w_unf[gi] = w_dec & ~w_inc & (r_cnt == 2'd0);
            assign w_nz[gi]  = (r_cnt != 2'd0);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= 2'd0;
                end else if (flush) begin
                    r_cnt <= 2'd0;
                end else if (w_inc && !w_dec && r_cnt != 2'd3) begin
                    r_cnt <= r_cnt + 2'd1;
                end else if (w_dec && !w_inc && r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((|w_ovf) || (|w_unf)) begin
            r_err <= 1'b1;
        end
    end

    assign chk1_busy   = w_nz[chk1_sel];
    assign chk2_busy   = w_nz[chk2_sel];
    assign write       = r_write;
    assign writeregsel = r_writeregsel;
    assign writedata   = r_writedata;
    assign err         = r_err;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed bench for rf_write_arbiter, checked every cycle
// against a behavioural model of grants, write port and pending counts.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0;
    logic [2:0]  a_reg = 3'd0;
    logic [15:0] a_data = 16'd0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [2:0]  b_reg = 3'd0;
    logic [15:0] b_data = 16'd0;
    logic        b_ready;
    logic        reserve_en = 1'b0;
    logic [2:0]  reserve_reg = 3'd0;
    logic [2:0]  chk1_sel = 3'd0;
    logic [2:0]  chk2_sel = 3'd0;
    logic        chk1_busy;
    logic        chk2_busy;
    logic        flush = 1'b0;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic        err;

    rf_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg),
        .chk1_sel(chk1_sel), .chk2_sel(chk2_sel),
        .chk1_busy(chk1_busy), .chk2_busy(chk2_busy),
        .flush(flush), .write(write), .writeregsel(writeregsel),
        .writedata(writedata), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the outputs must be after the most recent edge.
    int          m_cnt [8];
    bit          m_rr;
    bit          m_wr;
    logic [2:0]  m_sel;
    logic [15:0] m_data;
    bit          m_err;
    bit          m_ga;
    bit          m_gb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_rr = 0; m_wr = 0; m_sel = 3'd0; m_data = 16'd0; m_err = 0;
        m_ga = 0; m_gb = 0;
    endtask

    // Compare current DUT outputs with the model, then advance the model
    // across the coming clock edge using the currently driven inputs.
    task automatic model_step();
        bit ga, gb;
        int d [8];
        logic [2:0]  greg;
        logic [15:0] gdata;
        ga = !flush && a_valid && (!b_valid || !m_rr);
        gb = !flush && b_valid && (!a_valid ||  m_rr);
        chk("a_ready", 32'(a_ready), 32'(ga));
        chk("b_ready", 32'(b_ready), 32'(gb));
        chk("chk1_busy", 32'(chk1_busy), 32'(m_cnt[chk1_sel] != 0));
        chk("chk2_busy", 32'(chk2_busy), 32'(m_cnt[chk2_sel] != 0));
        chk("write", 32'(write), 32'(m_wr));
        chk("writeregsel", 32'(writeregsel), 32'(m_sel));
        chk("writedata", 32'(writedata), 32'(m_data));
        chk("err", 32'(err), 32'(m_err));
        if (flush) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_rr = 0;
            m_wr = 0;
        end else begin
            for (int i = 0; i < 8; i++) d[i] = 0;
            if (reserve_en) d[reserve_reg] = d[reserve_reg] + 1;
            if (ga || gb) begin
                greg  = ga ? a_reg  : b_reg;
                gdata = ga ? a_data : b_data;
                d[greg] = d[greg] - 1;
                m_wr = 1; m_sel = greg; m_data = gdata;
                if (a_valid && b_valid) m_rr = ga;
                $display("xfer %s reg=%0d data=%h t=%0t", ga ? "A" : "B", greg, gdata, $time);
            end else begin
                m_wr = 0;
            end
            for (int i = 0; i < 8; i++) begin
                if (d[i] > 0) begin
                    if (m_cnt[i] == 3) m_err = 1; else m_cnt[i] = m_cnt[i] + 1;
                end else if (d[i] < 0) begin
                    if (m_cnt[i] == 0) m_err = 1; else m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
        m_ga = ga;
        m_gb = gb;
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; reserve_en = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        a_valid = 1;
        #1;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_sel", 32'(writeregsel), 32'd0);
        chk("rst_data", 32'(writedata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_busy", 32'(chk1_busy | chk2_busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        idle_inputs();
    endtask

    initial begin
        bit pa, pb;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single requester A.
        a_valid = 1; a_reg = 3'd3; a_data = 16'h1234;
        #1;
        chk("d1_a_ready", 32'(a_ready), 32'd1);
        cycle();
        a_valid = 0;
        chk("d1_write", 32'(write), 32'd1);
        chk("d1_sel", 32'(writeregsel), 32'd3);
        chk("d1_data", 32'(writedata), 32'h1234);
        cycle();
        chk("d1_write_off", 32'(write), 32'd0);

        // Contention on the same register.
        do_reset();
        a_valid = 1; a_reg = 3'd1; a_data = 16'hAAAA;
        b_valid = 1; b_reg = 3'd1; b_data = 16'h5555;
        cycle();
        chk("d2_first", 32'(writedata), 32'hAAAA);
        chk("d2_first_sel", 32'(writeregsel), 32'd1);
        cycle();
        chk("d2_second", 32'(writedata), 32'h5555);
        chk("d2_second_wr", 32'(write), 32'd1);
        chk("d2_model_rr", 32'(m_rr), 32'd0);
        #1;
        chk("d2_rr_back_to_a", 32'(a_ready), 32'd1);
        idle_inputs();
        cycle();

        // Scoreboard.
        do_reset();
        chk1_sel = 3'd5; chk2_sel = 3'd0;
        reserve_en = 1; reserve_reg = 3'd5;
        cycle();
        cycle();
        reserve_en = 0;
        #1;
        chk("d3_busy2", 32'(chk1_busy), 32'd1);
        a_valid = 1; a_reg = 3'd5; a_data = 16'h0001;
        cycle();
        chk("d3_busy1", 32'(chk1_busy), 32'd1);
        cycle();
        chk("d3_busy0", 32'(chk1_busy), 32'd0);
        a_valid = 0; reserve_en = 1;
        cycle();
        a_valid = 1; a_data = 16'h0002;
        cycle();
        chk("d3_same_cycle", 32'(chk1_busy), 32'd1);
        reserve_en = 0;
        cycle();
        a_valid = 0;
        chk("d3_drained", 32'(chk1_busy), 32'd0);
        chk("d3_no_err", 32'(err), 32'd0);

        // Errors: underflow, sticky through flush, overflow.
        do_reset();
        a_valid = 1; a_reg = 3'd2; a_data = 16'hBEEF;
        cycle();
        a_valid = 0;
        chk("d4_underflow", 32'(err), 32'd1);
        flush = 1;
        cycle();
        flush = 0;
        chk("d4_sticky", 32'(err), 32'd1);
        do_reset();
        chk2_sel = 3'd7;
        reserve_en = 1; reserve_reg = 3'd7;
        for (int i = 0; i < 3; i++) cycle();
        chk("d4_cnt3_no_err", 32'(err), 32'd0);
        cycle();
        reserve_en = 0;
        chk("d4_overflow", 32'(err), 32'd1);
        chk("d4_model_cnt", 32'(m_cnt[7]), 32'd3);
        a_valid = 1; a_reg = 3'd7;
        cycle();
        cycle();
        chk("d4_cnt1_busy", 32'(chk2_busy), 32'd1);
        cycle();
        a_valid = 0;
        chk("d4_cnt0_idle", 32'(chk2_busy), 32'd0);

        // Flush with pending counts and a waiting requester.
        do_reset();
        chk1_sel = 3'd4;
        reserve_en = 1; reserve_reg = 3'd4;
        cycle();
        reserve_en = 0;
        flush = 1; a_valid = 1; a_reg = 3'd4; a_data = 16'h7777;
        #1;
        chk("d5_no_grant", 32'(a_ready), 32'd0);
        chk("d5_busy_before", 32'(chk1_busy), 32'd1);
        cycle();
        flush = 0; a_valid = 0;
        chk("d5_write", 32'(write), 32'd0);
        chk("d5_busy_after", 32'(chk1_busy), 32'd0);

        // Asynchronous reset while a write is presented.
        reserve_en = 1; reserve_reg = 3'd6; chk2_sel = 3'd6;
        a_valid = 1; a_reg = 3'd0; a_data = 16'hCAFE;
        cycle();
        idle_inputs();
        chk("d6_write_before", 32'(write), 32'd1);
        #2;
        do_reset();

        // Randomised traffic.
        pa = 0; pb = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                pa = 0; pb = 0;
            end
            flush       = ($urandom_range(0, 15) == 0);
            reserve_en  = ($urandom_range(0, 2) == 0);
            reserve_reg = 3'($urandom_range(0, 7));
            chk1_sel    = 3'($urandom_range(0, 7));
            chk2_sel    = 3'($urandom_range(0, 7));
            if (!pa && $urandom_range(0, 1) == 1) begin
                pa = 1; a_reg = 3'($urandom_range(0, 7)); a_data = 16'($urandom);
            end
            if (!pb && $urandom_range(0, 1) == 1) begin
                pb = 1; b_reg = 3'($urandom_range(0, 7)); b_data = 16'($urandom);
            end
            a_valid = pa;
            b_valid = pb;
            cycle();
            if (m_ga) pa = 0;
            if (m_gb) pb = 0;
            a_valid = pa;
            b_valid = pb;
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
